sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/cpu_arb_pkg.sv | 31 +++
 rtl/arb_resp_tracker.sv | 51 +++++
 rtl/sram_arbiter.sv | 128 ++++++++++++
 tb/tb_sram_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_arb_pkg.sv
// Shared types and constants for the instruction/data SRAM arbiter.
package cpu_arb_pkg;

    localparam int unsigned ADDR_W           = 32;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned WEN_W            = 4;
    localparam int unsigned CNT_W            = 16;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    // Response tag field widths
    localparam int unsigned SRC_W            = 1;

    typedef enum logic [SRC_W-1:0] {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    // Tag captured on every grant and consumed one cycle later
    typedef struct packed {
        logic valid;
        src_e src;
        logic squash;
        logic write;
    } resp_tag_t;

    // Word-align a byte address
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/arb_resp_tracker.sv
// Holds the tag of the last grant and steers the SRAM read data back
// to whichever side was granted, one cycle after the grant.
module arb_resp_tracker
    import cpu_arb_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              cancel,
    input  resp_tag_t         grant_tag,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata
);

    resp_tag_t tag_q;
    resp_tag_t tag_nxt;

    // Tag register; a reset discards any pending response
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_nxt;
        end
    end

    // Next tag is whatever was granted this cycle (valid=0 when idle)
    always_comb begin
        tag_nxt = grant_tag;
    end

    // Response steering: cancel kills inst returns, never data returns
    always_comb begin
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        if (resetn && tag_q.valid) begin
            if (tag_q.src == SRC_DATA) begin
                data_data_ok = 1'b1;
                data_rdata   = tag_q.write ? '0 : sram_rdata;
            end else if (!tag_q.squash && !cancel) begin
                inst_data_ok = 1'b1;
                inst_rdata   = sram_rdata;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates fetch and MEM-stage requests onto one synchronous SRAM.
// Data has priority unless inst has been starved for STARVE_LIMIT grants.
module sram_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cancel,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic [WEN_W-1:0]  data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              sram_en,
    output logic [WEN_W-1:0]  sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,

    output logic [CNT_W-1:0]  inst_grant_cnt,
    output logic [CNT_W-1:0]  data_grant_cnt
);

    localparam int unsigned STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_cnt_nxt;
    logic [CNT_W-1:0]    inst_cnt_q;
    logic [CNT_W-1:0]    inst_cnt_nxt;
    logic [CNT_W-1:0]    data_cnt_q;
    logic [CNT_W-1:0]    data_cnt_nxt;
    logic                starved;
    logic                inst_gnt;
    logic                data_gnt;
    resp_tag_t           grant_tag;

    // Grant decision; nothing is granted while reset is held
    always_comb begin
        starved  = (starve_cnt == STARVE_MAX);
        data_gnt = resetn && data_req && !(inst_req && starved);
        inst_gnt = resetn && inst_req && !data_gnt;
    end

    // SRAM request path and accept strobes from the winning side
    always_comb begin
        sram_en      = 1'b0;
        sram_wen     = '0;
        sram_addr    = '0;
        sram_wdata   = '0;
        inst_addr_ok = inst_gnt;
        data_addr_ok = data_gnt;
        if (data_gnt) begin
            sram_en    = 1'b1;
            sram_wen   = data_wen;
            sram_addr  = word_addr(data_addr);
            sram_wdata = data_wdata;
        end else if (inst_gnt) begin
            sram_en    = 1'b1;
            sram_addr  = word_addr(inst_addr);
        end
    end

    // Tag handed to the response tracker for this cycle's grant
    always_comb begin
        grant_tag        = '0;
        grant_tag.valid  = inst_gnt || data_gnt;
        grant_tag.src    = data_gnt ? SRC_DATA : SRC_INST;
        grant_tag.squash = inst_gnt && cancel;
        grant_tag.write  = data_gnt && (data_wen != '0);
    end

    // Next-state for starvation tracking and grant counters
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (!inst_req || inst_gnt) begin
            starve_cnt_nxt = '0;
        end else if (data_gnt && !starved) begin
            starve_cnt_nxt = starve_cnt + STARVE_W'(1);
        end
        inst_cnt_nxt = inst_cnt_q + CNT_W'(inst_gnt);
        data_cnt_nxt = data_cnt_q + CNT_W'(data_gnt);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            starve_cnt <= '0;
            inst_cnt_q <= '0;
            data_cnt_q <= '0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
            inst_cnt_q <= inst_cnt_nxt;
            data_cnt_q <= data_cnt_nxt;
        end
    end

    // Counters read as zero for the whole reset window
    always_comb begin
        inst_grant_cnt = resetn ? inst_cnt_q : '0;
        data_grant_cnt = resetn ? data_cnt_q : '0;
    end

    arb_resp_tracker u_resp (
        .clk          (clk),
        .resetn       (resetn),
        .cancel       (cancel),
        .grant_tag    (grant_tag),
        .sram_rdata   (sram_rdata),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural 1-cycle SRAM.
module tb_sram_arbiter;

    localparam int G_NONE = 0;
    localparam int G_INST = 1;
    localparam int G_DATA = 2;

    logic        clk        = 1'b0;
    logic        resetn     = 1'b0;
    logic        cancel     = 1'b0;
    logic        inst_req   = 1'b0;
    logic [31:0] inst_addr  = '0;
    logic        data_req   = 1'b0;
    logic [3:0]  data_wen   = '0;
    logic [31:0] data_addr  = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] sram_rdata = '0;

    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, sram_en;
    logic [31:0] inst_rdata, data_rdata, sram_addr, sram_wdata;
    logic [3:0]  sram_wen;
    logic [15:0] inst_grant_cnt, data_grant_cnt;

    int unsigned cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    typedef struct {
        int unsigned due;
        bit          is_data;
        bit          squash;
        logic [31:0] rdata;
    } sb_item_t;

    sb_item_t    sb_q[$];
    logic [31:0] sram_mem [0:1023];
    logic [31:0] ref_mem  [0:1023];

    sram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .cancel         (cancel),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .data_req       (data_req),
        .data_wen       (data_wen),
        .data_addr      (data_addr),
        .data_wdata     (data_wdata),
        .data_addr_ok   (data_addr_ok),
        .data_data_ok   (data_data_ok),
        .data_rdata     (data_rdata),
        .sram_en        (sram_en),
        .sram_wen       (sram_wen),
        .sram_addr      (sram_addr),
        .sram_wdata     (sram_wdata),
        .sram_rdata     (sram_rdata),
        .inst_grant_cnt (inst_grant_cnt),
        .data_grant_cnt (data_grant_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] wen);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (wen[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Behavioural SRAM: read data appears the cycle after the access
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wen == 4'b0000) sram_rdata <= sram_mem[sram_addr[11:2]];
            else sram_mem[sram_addr[11:2]] <= merge(sram_mem[sram_addr[11:2]], sram_wdata, sram_wen);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", tag, cyc, got, exp);
        end
    endtask

    // Response checker: pops the item due this cycle, otherwise expects silence
    always @(negedge clk) begin : monitor
        sb_item_t    e;
        logic        e_iok, e_dok;
        logic [31:0] e_ird, e_drd;
        e_iok = 1'b0; e_dok = 1'b0; e_ird = '0; e_drd = '0;
        if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            if (e.is_data) begin
                e_dok = 1'b1;
                e_drd = e.rdata;
            end else if (!e.squash && !cancel) begin
                e_iok = 1'b1;
                e_ird = e.rdata;
            end
        end
        check("inst_data_ok", 32'(inst_data_ok), 32'(e_iok));
        check("inst_rdata",   inst_rdata,        e_ird);
        check("data_data_ok", 32'(data_data_ok), 32'(e_dok));
        check("data_rdata",   data_rdata,        e_drd);
    end

    // One clock of stimulus with the grant the specification calls for
    task automatic drive_cycle(input bit ireq, input logic [31:0] iaddr, input bit dreq,
                               input logic [3:0] dwen, input logic [31:0] daddr,
                               input logic [31:0] dwdata, input bit cncl, input int g);
        sb_item_t    it;
        logic [31:0] ga;
        inst_req = ireq; inst_addr = iaddr; data_req = dreq; data_wen = dwen;
        data_addr = daddr; data_wdata = dwdata; cancel = cncl;
        ga = ((g == G_DATA) ? daddr : iaddr) & ~32'h3;
        @(negedge clk);
        check("inst_addr_ok", 32'(inst_addr_ok), 32'(g == G_INST));
        check("data_addr_ok", 32'(data_addr_ok), 32'(g == G_DATA));
        check("sram_en",      32'(sram_en),      32'(g != G_NONE));
        check("sram_wen",     32'(sram_wen),     (g == G_DATA) ? 32'(dwen) : 32'h0);
        check("sram_wdata",   sram_wdata,        (g == G_DATA) ? dwdata : 32'h0);
        if (g != G_NONE) begin
            check("sram_addr", sram_addr, ga);
            it.due     = cyc + 1;
            it.is_data = (g == G_DATA);
            it.squash  = (g == G_INST) && cncl;
            if (g == G_DATA && dwen != 4'b0000) begin
                it.rdata = '0;
                ref_mem[ga[11:2]] = merge(ref_mem[ga[11:2]], dwdata, dwen);
            end else begin
                it.rdata = ref_mem[ga[11:2]];
            end
            sb_q.push_back(it);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input bit cncl);
        drive_cycle(1'b0, '0, 1'b0, '0, '0, '0, cncl, G_NONE);
    endtask

    // Two reset cycles with both requests up; nothing may be granted
    task automatic do_reset();
        resetn = 1'b0; inst_req = 1'b1; data_req = 1'b1; data_wen = '0; cancel = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_inst_addr_ok", 32'(inst_addr_ok), 32'h0);
            check("rst_data_addr_ok", 32'(data_addr_ok), 32'h0);
            check("rst_sram_en",      32'(sram_en),      32'h0);
            check("rst_sram_wen",     32'(sram_wen),     32'h0);
            check("rst_sram_addr",    sram_addr,         32'h0);
            check("rst_inst_cnt",     32'(inst_grant_cnt), 32'h0);
            check("rst_data_cnt",     32'(data_grant_cnt), 32'h0);
            @(posedge clk); #1;
        end
        inst_req = 1'b0; data_req = 1'b0; resetn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram_mem[i] = 32'hC0DE_0000 ^ (32'(i) << 2);
            ref_mem[i]  = sram_mem[i];
        end
        sram_mem[1] = 32'h2401_0001;
        ref_mem[1]  = 32'h2401_0001;

        do_reset();

        // Single inst read
        drive_cycle(1'b1, 32'hBFC0_0004, 1'b0, '0, '0, '0, 1'b0, G_INST);
        idle(1'b0);

        // Conflict: data first, then inst on the very next cycle
        drive_cycle(1'b1, 32'hBFC0_0004, 1'b1, '0, 32'h100, '0, 1'b0, G_DATA);
        drive_cycle(1'b1, 32'hBFC0_0004, 1'b0, '0, '0,      '0, 1'b0, G_INST);
        idle(1'b0);

        // Starvation from a clean state: D,D,D,D,I repeating
        do_reset();
        for (int i = 0; i < 10; i++)
            drive_cycle(1'b1, 32'h1000, 1'b1, '0, 32'h300 + 32'(4 * i), '0, 1'b0,
                        ((i % 5) == 4) ? G_INST : G_DATA);
        idle(1'b0);
        check("starve_data_cnt", 32'(data_grant_cnt), 32'd8);
        check("starve_inst_cnt", 32'(inst_grant_cnt), 32'd2);

        // Partial write beats a concurrent inst request; inst goes next; read back
        drive_cycle(1'b1, 32'h1000, 1'b1, 4'b0011, 32'h204, 32'hAABB_CCDD, 1'b0, G_DATA);
        drive_cycle(1'b1, 32'h1000, 1'b0, '0, '0, '0, 1'b0, G_INST);
        drive_cycle(1'b0, '0, 1'b1, '0, 32'h206, '0, 1'b0, G_DATA);
        idle(1'b0);

        // Cancel: squashed inst grant, data returns under cancel, late cancel
        drive_cycle(1'b0, '0, 1'b1, '0, 32'h100, '0, 1'b0, G_DATA);
        drive_cycle(1'b1, 32'hBFC0_0004, 1'b0, '0, '0, '0, 1'b1, G_INST);
        drive_cycle(1'b0, '0, 1'b1, '0, 32'h204, '0, 1'b0, G_DATA);
        drive_cycle(1'b1, 32'hBFC0_0004, 1'b0, '0, '0, '0, 1'b0, G_INST);
        idle(1'b1);
        idle(1'b0);

        // Reset the cycle after a grant: the pending response is dropped
        drive_cycle(1'b0, '0, 1'b1, '0, 32'h100, '0, 1'b0, G_DATA);
        do_reset();
        idle(1'b0);
        check("post_rst_inst_cnt", 32'(inst_grant_cnt), 32'h0);
        check("post_rst_data_cnt", 32'(data_grant_cnt), 32'h0);

        // Counter wrap: 65535 data grants, then one more
        for (int i = 0; i < 65535; i++)
            drive_cycle(1'b0, '0, 1'b1, '0, 32'($urandom_range(0, 1023)) << 2, '0, 1'b0, G_DATA);
        idle(1'b0);
        check("cnt_ffff", 32'(data_grant_cnt), 32'h0000_FFFF);
        drive_cycle(1'b0, '0, 1'b1, '0, 32'h100, '0, 1'b0, G_DATA);
        idle(1'b0);
        check("cnt_wrap", 32'(data_grant_cnt), 32'h0);
        check("cnt_inst_after_wrap", 32'(inst_grant_cnt), 32'h0);
        check("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
